// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage-register state encoding and per-stage field widths.
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   // IF/ID boundary
   localparam int unsigned              IFID_CTRL_W   = 4;
   localparam int unsigned              IFID_DATA_W   = 64;
   localparam logic [IFID_CTRL_W-1:0]   IFID_CTRL_RST = '0;

   // ID/EX boundary
   localparam int unsigned              IDEX_CTRL_W   = 16;
   localparam int unsigned              IDEX_DATA_W   = 96;
   localparam logic [IDEX_CTRL_W-1:0]   IDEX_CTRL_RST = '0;

   // EX/MEM boundary
   localparam int unsigned              EXMEM_CTRL_W   = 12;
   localparam int unsigned              EXMEM_DATA_W   = 72;
   localparam logic [EXMEM_CTRL_W-1:0]  EXMEM_CTRL_RST = '0;

   // MEM/WB boundary
   localparam int unsigned              MEMWB_CTRL_W   = 6;
   localparam int unsigned              MEMWB_DATA_W   = 40;
   localparam logic [MEMWB_CTRL_W-1:0]  MEMWB_CTRL_RST = '0;

   function automatic logic [1:0] state_occ(input stage_state_e s);
      case (s)
         ST_ONE:  return 2'd1;
         ST_TWO:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One pipeline entry: valid + control (reset to bubble) + data (no reset), with load/clear.
module pipe_entry #(
   parameter int unsigned        CTRL_W   = 16,
   parameter int unsigned        DATA_W   = 96,
   parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   // clear wins over load so a killed entry always reads as a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_RST;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_RST;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_ctrl  <= i_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (i_load && !i_clear) begin
         r_data <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush and stall counter.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned        CTRL_W   = 16,
   parameter int unsigned        DATA_W   = 96,
   parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
   parameter int unsigned        SKID     = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [15:0]       stall_cnt
);

   localparam bit SKID_EN = (SKID != 0);

   stage_state_e      r_state;
   stage_state_e      w_state_nxt;
   logic              r_rdy;
   logic [1:0]        r_occ;
   logic [15:0]       r_stall;

   logic              w_push;
   logic              w_pop;
   logic              w_main_load;
   logic              w_main_from_skid;
   logic              w_main_clear;
   logic              w_skid_load;
   logic              w_skid_clear;

   logic              w_main_valid;
   logic [CTRL_W-1:0] w_main_ctrl;
   logic [DATA_W-1:0] w_main_data;
   logic              w_skid_valid;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic [DATA_W-1:0] w_skid_data;

   // without the skid entry, ready also opens when the held entry leaves this cycle
   assign in_ready = r_rdy & (SKID_EN | ~w_main_valid | out_ready);
   assign w_push   = in_valid & in_ready;
   assign w_pop    = w_main_valid & out_ready;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_EMPTY;
         r_rdy   <= 1'b0;
         r_occ   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_rdy   <= (w_state_nxt != ST_TWO);
         r_occ   <= state_occ(w_state_nxt);
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_main_clear     = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;
      if (flush) begin
         w_state_nxt  = ST_EMPTY;
         w_main_clear = 1'b1;
         w_skid_clear = 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_main_load = 1'b1;
                  w_state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  w_main_load = 1'b1;
               end else if (w_pop) begin
                  w_main_clear = 1'b1;
                  w_state_nxt  = ST_EMPTY;
               end else if (w_push && SKID_EN) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = ST_TWO;
               end
            end
            ST_TWO: begin
               if (w_pop && w_skid_valid) begin
                  w_main_load      = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_skid_clear     = 1'b1;
                  w_state_nxt      = ST_ONE;
               end
            end
            default: begin
               w_state_nxt  = ST_EMPTY;
               w_main_clear = 1'b1;
               w_skid_clear = 1'b1;
            end
         endcase
      end
   end

   // stall counter keeps counting across flushes; only reset clears it
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_stall <= 16'd0;
      end else if (w_main_valid && !out_ready && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   pipe_entry #(
      .CTRL_W   (CTRL_W),
      .DATA_W   (DATA_W),
      .CTRL_RST (CTRL_RST)
   ) u_main (
      .clk     (Clk),
      .rst_n   (Reset),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_ctrl  (w_main_from_skid ? w_skid_ctrl : in_ctrl),
      .i_data  (w_main_from_skid ? w_skid_data : in_data),
      .o_valid (w_main_valid),
      .o_ctrl  (w_main_ctrl),
      .o_data  (w_main_data)
   );

   pipe_entry #(
      .CTRL_W   (CTRL_W),
      .DATA_W   (DATA_W),
      .CTRL_RST (CTRL_RST)
   ) u_skid (
      .clk     (Clk),
      .rst_n   (Reset),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_ctrl  (in_ctrl),
      .i_data  (in_data),
      .o_valid (w_skid_valid),
      .o_ctrl  (w_skid_ctrl),
      .o_data  (w_skid_data)
   );

   assign out_valid = w_main_valid;
   assign out_ctrl  = w_main_ctrl;
   assign out_data  = w_main_data;
   assign occupancy = r_occ;
   assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances checked against a queue model.
module tb_pipe_stage_reg;

   localparam int unsigned CW = 16;
   localparam int unsigned DW = 96;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   logic          Clk       = 1'b0;
   logic          Reset     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          flush     = 1'b0;
   logic          out_ready = 1'b0;
   logic [CW-1:0] in_ctrl   = '0;
   logic [DW-1:0] in_data   = '0;

   logic          ov  [2];
   logic          ir  [2];
   logic [CW-1:0] oc  [2];
   logic [DW-1:0] od  [2];
   logic [1:0]    occ [2];
   logic [15:0]   sc  [2];

   int n_checks = 0;
   int n_fail   = 0;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(16'h0000), .SKID(0)) u_dut0 (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl),
      .in_data(in_data), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
      .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0]), .stall_cnt(sc[0]));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(16'h0000), .SKID(1)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl),
      .in_data(in_data), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
      .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1]), .stall_cnt(sc[1]));

   always #5 Clk = ~Clk;

   // Model: each stage is a bounded FIFO (capacity 1 without skid, 2 with skid)
   ent_t        mq0[$];
   ent_t        mq1[$];
   int unsigned mcnt0 = 0;
   int unsigned mcnt1 = 0;
   bit          mrdy  = 1'b0;

   function automatic bit exp_rdy(input int m);
      if (m == 1) return mrdy && (mq1.size() < 2);
      return mrdy && ((mq0.size() == 0) || (out_ready == 1'b1));
   endfunction

   always @(posedge Clk or negedge Reset) begin
      ent_t e;
      bit   p0;
      bit   p1;
      if (!Reset) begin
         mq0.delete();
         mq1.delete();
         mcnt0 = 0;
         mcnt1 = 0;
         mrdy  = 1'b0;
      end else begin
         e  = {in_ctrl, in_data};
         p0 = in_valid && exp_rdy(0);
         p1 = in_valid && exp_rdy(1);
         if (mq0.size() > 0 && !out_ready && mcnt0 < 32'hFFFF) mcnt0++;
         if (mq1.size() > 0 && !out_ready && mcnt1 < 32'hFFFF) mcnt1++;
         if (flush) begin
            mq0.delete();
            mq1.delete();
         end else begin
            if (mq0.size() > 0 && out_ready) void'(mq0.pop_front());
            if (mq1.size() > 0 && out_ready) void'(mq1.pop_front());
            if (p0) mq0.push_back(e);
            if (p1) mq1.push_back(e);
         end
         mrdy = 1'b1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_one(input int m, input int sz, input ent_t h, input int unsigned cnt);
      check($sformatf("d%0d out_valid", m), 128'(ov[m]), 128'(sz > 0));
      check($sformatf("d%0d out_ctrl", m), 128'(oc[m]), (sz > 0) ? 128'(h.c) : 128'd0);
      if (sz > 0) check($sformatf("d%0d out_data", m), 128'(od[m]), 128'(h.d));
      check($sformatf("d%0d occupancy", m), 128'(occ[m]), 128'(sz));
      check($sformatf("d%0d stall_cnt", m), 128'(sc[m]), 128'(cnt));
      check($sformatf("d%0d in_ready", m), 128'(ir[m]), 128'(exp_rdy(m)));
   endtask

   always @(posedge Clk) begin
      #1;
      if (Reset === 1'b1) begin
         compare_one(0, mq0.size(), (mq0.size() > 0) ? mq0[0] : '0, mcnt0);
         compare_one(1, mq1.size(), (mq1.size() > 0) ? mq1[0] : '0, mcnt1);
      end
   end

   task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit r, input bit f);
      @(negedge Clk);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   task automatic settle();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      for (int m = 0; m < 2; m++) begin
         check($sformatf("%s d%0d out_valid", tag, m), 128'(ov[m]), 128'd0);
         check($sformatf("%s d%0d in_ready", tag, m), 128'(ir[m]), 128'd0);
         check($sformatf("%s d%0d out_ctrl", tag, m), 128'(oc[m]), 128'd0);
         check($sformatf("%s d%0d occupancy", tag, m), 128'(occ[m]), 128'd0);
         check($sformatf("%s d%0d stall_cnt", tag, m), 128'(sc[m]), 128'd0);
      end
   endtask

   initial begin
      #12;
      check_reset_vals("reset");
      @(negedge Clk);
      Reset = 1'b1;
      settle();
      check("post-reset d1 in_ready", 128'(ir[1]), 128'd1);
      check("post-reset d0 in_ready", 128'(ir[0]), 128'd1);

      // first push latency
      drive(1'b1, 16'h00A5, 96'd1, 1'b1, 1'b0);
      settle();
      for (int m = 0; m < 2; m++) begin
         check($sformatf("first d%0d out_valid", m), 128'(ov[m]), 128'd1);
         check($sformatf("first d%0d out_ctrl", m), 128'(oc[m]), 128'h00A5);
         check($sformatf("first d%0d out_data", m), 128'(od[m]), 128'd1);
         check($sformatf("first d%0d occupancy", m), 128'(occ[m]), 128'd1);
      end
      drive(1'b0, 16'h0, 96'd0, 1'b1, 1'b0);
      settle();
      check("drain d1 out_valid", 128'(ov[1]), 128'd0);

      // fill the skid buffer while downstream stalls
      drive(1'b1, 16'h000A, 96'd10, 1'b0, 1'b0);
      drive(1'b1, 16'h000B, 96'd11, 1'b0, 1'b0);
      settle();
      check("two d1 occupancy", 128'(occ[1]), 128'd2);
      check("two d1 in_ready", 128'(ir[1]), 128'd0);
      check("two d1 out_ctrl", 128'(oc[1]), 128'h000A);
      check("two d1 stall_cnt", 128'(sc[1]), 128'd1);
      drive(1'b0, 16'h0, 96'd0, 1'b0, 1'b0);
      settle();
      check("two d1 stall_cnt+1", 128'(sc[1]), 128'd2);
      drive(1'b0, 16'h0, 96'd0, 1'b1, 1'b0);
      settle();
      check("unload d1 out_ctrl B", 128'(oc[1]), 128'h000B);
      check("unload d1 out_data B", 128'(od[1]), 128'd11);
      check("unload d1 occupancy", 128'(occ[1]), 128'd1);
      settle();
      check("unload d1 empty", 128'(ov[1]), 128'd0);

      // flush from full state with simultaneous push
      drive(1'b1, 16'h000C, 96'd12, 1'b0, 1'b0);
      drive(1'b1, 16'h000D, 96'd13, 1'b0, 1'b0);
      drive(1'b1, 16'h000E, 96'd14, 1'b0, 1'b1);
      settle();
      check("flush d1 out_valid", 128'(ov[1]), 128'd0);
      check("flush d1 out_ctrl", 128'(oc[1]), 128'd0);
      check("flush d1 occupancy", 128'(occ[1]), 128'd0);
      check("flush d1 in_ready", 128'(ir[1]), 128'd1);
      drive(1'b0, 16'h0, 96'd0, 1'b1, 1'b0);
      settle();
      check("flush d1 input dropped", 128'(ov[1]), 128'd0);

      // back-to-back streaming
      for (int i = 1; i <= 100; i++) drive(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
      drive(1'b0, 16'h0, 96'd0, 1'b1, 1'b0);
      repeat (3) @(posedge Clk);

      // random traffic
      repeat (3000) begin
         drive(1'($urandom_range(0, 1)), CW'($urandom()),
               {$urandom(), $urandom(), $urandom()},
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
      end
      drive(1'b0, 16'h0, 96'd0, 1'b1, 1'b0);
      repeat (3) @(posedge Clk);

      // stall counter saturation, then async reset mid-stall
      drive(1'b1, 16'h005A, 96'd7, 1'b0, 1'b0);
      drive(1'b0, 16'h0, 96'd0, 1'b0, 1'b0);
      repeat (70000) @(posedge Clk);
      #1;
      check("sat d1 stall_cnt", 128'(sc[1]), 128'hFFFF);
      check("sat d0 stall_cnt", 128'(sc[0]), 128'hFFFF);
      check("sat d1 out_valid", 128'(ov[1]), 128'd1);
      @(posedge Clk);
      #2;
      Reset = 1'b0;
      #1;
      check_reset_vals("async");
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 16: width of control field (ALU op, enables, mem size/sign bits).
REQ-002 Parameter DATA_W, default 96: width of data field (operands, PC, immediates, register numbers).
REQ-003 Parameter CTRL_RST, default all-zero: control value forced on reset and flush (bubble = NOP).
REQ-004 Parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-005 Clk  input  1  sole clock, rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream stage holds a valid instruction.
REQ-008 in_ready  output  1  stage accepts in_* this cycle.
REQ-009 in_ctrl  input  CTRL_W  control signals from upstream.
REQ-010 in_data  input  DATA_W  data fields from upstream.
REQ-011 flush  input  1  synchronous kill of all held entries (branch/exception).
REQ-012 out_valid  output  1  out_* holds a valid instruction.
REQ-013 out_ready  input  1  downstream consumes out_* this cycle.
REQ-014 out_ctrl  output  CTRL_W  registered control; equals CTRL_RST whenever out_valid=0.
REQ-015 out_data  output  DATA_W  registered data.
REQ-016 occupancy  output  2  entries held (0..2; max 1 when SKID=0).
REQ-017 stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same rising edge.
REQ-019 States (SKID=1): EMPTY, ONE (main entry valid), TWO (main and skid valid); out_* always driven from main.
REQ-020 EMPTY: push -> ONE, main loaded; otherwise stay.
REQ-021 ONE: push & pop -> ONE, main reloaded; pop only -> EMPTY; push only -> TWO, skid loaded; neither -> stay.
REQ-022 TWO: pop -> ONE, skid copied to main; no pop -> stay; push impossible since in_ready=0.
REQ-023 SKID=1: in_ready is registered, equals 1 in EMPTY/ONE and 0 in TWO; no combinational path from out_ready.
REQ-024 SKID=0: in_ready = !out_valid | out_ready; no TWO state.
REQ-025 Latency: input pushed into EMPTY appears on out_* the next cycle; order strictly FIFO; no entry duplicated or dropped except by flush.
REQ-026 Flush: next state EMPTY, out_valid=0, out_ctrl=CTRL_RST, data registers hold value; flush overrides a simultaneous push (input discarded) and pop.
REQ-027 stall_cnt increments by 1 per stall cycle, saturates at 16'hFFFF, unaffected by flush.
REQ-028 Data registers need no reset; control and valid registers do.

Reset
REQ-029 While Reset=0: state EMPTY, out_valid=0, in_ready=0, out_ctrl=CTRL_RST, occupancy=0, stall_cnt=0.
REQ-030 First cycle after Reset deasserts: in_ready=1; reset asserted mid-transfer discards all entries immediately without waiting for Clk.

Structure
REQ-031 State encoding (EMPTY/ONE/TWO) and the per-stage CTRL_W/DATA_W/CTRL_RST constants for IF/ID, ID/EX, EX/MEM, MEM/WB belong in a shared pipeline package.
REQ-032 One sub-module, pipe_entry (valid + ctrl + data register with load/clear), instantiated as main and skid entries.

Verification
REQ-033 Reset=0 then release, in_valid=1 in_ctrl=16'h00A5 in_data=1, out_ready=1 -> next cycle out_valid=1 out_ctrl=16'h00A5, occupancy=1.
REQ-034 SKID=1, out_ready=0, push A then B -> occupancy=2, in_ready=0, stall_cnt counts; out_ready=1 -> A then B on consecutive cycles.
REQ-035 State TWO with flush=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0, input not captured.
REQ-036 Continuous in_valid=1 out_ready=1 streaming 1..100 -> outputs 1..100 in order, one per cycle, in_ready constantly 1.
REQ-037 out_ready=0 held 70000 cycles with out_valid=1 -> stall_cnt stops at 16'hFFFF; async Reset=0 mid-stall -> all outputs to reset values before next Clk edge.
